// File: rtl/cnt_obi_sequencer.sv
// OBI initiator that programs, runs and reads back a memory-mapped counter peripheral.
// One transaction outstanding at a time; each bus step is a REQ phase followed by an RSP phase.
module cnt_obi_sequencer #(
  parameter logic [31:0] THR_OFFS    = 32'h4,
  parameter logic [31:0] CTRL_OFFS   = 32'h0,
  parameter logic [31:0] VAL_OFFS    = 32'h8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [31:0] thr_i,
  input  logic        tc_int_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] cnt_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam bit          TimeoutEn = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TimerLast = TimeoutEn ? 32'(TIMEOUT_CYC - 1) : 32'h0;

  typedef enum logic [2:0] {
    StIdle,
    StWrThr,
    StWrClr,
    StWrEn,
    StWaitTc,
    StRdVal,
    StWrDis,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        rsp_q, rsp_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] base_q, base_d;
  logic [31:0] timer_q, timer_d;
  logic        timeout_q, timeout_d;
  logic [31:0] cnt_q, cnt_d;
  logic        launch;

  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    base_d    = base_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    launch    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d    = base_addr_i;
          timeout_d = 1'b0;
          state_d   = StWrThr;
          launch    = 1'b1;
        end
      end
      StWrThr, StWrClr, StWrEn, StRdVal, StWrDis: begin
        if (!rsp_q) begin
          // Request stays up with stable attributes until granted.
          if (bus_gnt_i) begin
            rsp_d = 1'b1;
            req_d = 1'b0;
          end
        end else if (bus_rvalid_i) begin
          rsp_d = 1'b0;
          case (state_q)
            StWrThr: begin
              state_d = StWrClr;
              launch  = 1'b1;
            end
            StWrClr: begin
              state_d = StWrEn;
              launch  = 1'b1;
            end
            StWrEn: begin
              state_d = StWaitTc;
              timer_d = 32'h0;
            end
            StRdVal: begin
              state_d = StWrDis;
              cnt_d   = bus_rdata_i;
              launch  = 1'b1;
            end
            default: state_d = StDone;
          endcase
        end
      end
      StWaitTc: begin
        // A terminal count on the final timer cycle still counts as a normal finish.
        if (tc_int_i) begin
          state_d   = StRdVal;
          timeout_d = 1'b0;
          launch    = 1'b1;
        end else if (TimeoutEn && (timer_q == TimerLast)) begin
          state_d   = StRdVal;
          timeout_d = 1'b1;
          launch    = 1'b1;
        end else begin
          timer_d = timer_q + 32'h1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (launch) begin
      req_d = 1'b1;
      rsp_d = 1'b0;
      we_d  = 1'b1;
      case (state_d)
        StWrThr: begin
          addr_d  = base_d + THR_OFFS;
          wdata_d = thr_i;
        end
        StWrClr: begin
          addr_d  = base_d + CTRL_OFFS;
          wdata_d = 32'h2;
        end
        StWrEn: begin
          addr_d  = base_d + CTRL_OFFS;
          wdata_d = 32'h1;
        end
        StRdVal: begin
          we_d    = 1'b0;
          addr_d  = base_d + VAL_OFFS;
          wdata_d = 32'h0;
        end
        default: begin
          addr_d  = base_d + CTRL_OFFS;
          wdata_d = 32'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      rsp_q     <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      base_q    <= 32'h0;
      timer_q   <= 32'h0;
      timeout_q <= 1'b0;
      cnt_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      rsp_q     <= rsp_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      base_q    <= base_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy_o      = (state_q != StIdle) && (state_q != StDone);
  assign done_o      = (state_q == StDone);
  assign timeout_o   = timeout_q;
  assign cnt_o       = cnt_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_be_o    = 4'hF;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_cnt_obi_sequencer.sv
// Bench for cnt_obi_sequencer: bench-side OBI target with random gnt/rvalid latency,
// expected transaction list, WAIT_TC length and latency derived from the sequence rules.
module tb_cnt_obi_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] thr_val;
  logic        tc_int;
  logic        busy, done, timeout;
  logic [31:0] cnt;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cnt_obi_sequencer #(
    .TIMEOUT_CYC(16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .thr_i        (thr_val),
    .tc_int_i     (tc_int),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_o    (timeout),
    .cnt_o        (cnt),
    .bus_req_o    (bus_req),
    .bus_we_o     (bus_we),
    .bus_be_o     (bus_be),
    .bus_addr_o   (bus_addr),
    .bus_wdata_o  (bus_wdata),
    .bus_gnt_i    (bus_gnt),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string name);
    chk($sformatf("%s:req", name), 32'(bus_req), 32'h0);
    chk($sformatf("%s:we", name), 32'(bus_we), 32'h0);
    chk($sformatf("%s:busy", name), 32'(busy), 32'h0);
    chk($sformatf("%s:done", name), 32'(done), 32'h0);
    chk($sformatf("%s:timeout", name), 32'(timeout), 32'h0);
    chk($sformatf("%s:addr", name), bus_addr, 32'h0);
    chk($sformatf("%s:wdata", name), bus_wdata, 32'h0);
    chk($sformatf("%s:cnt", name), cnt, 32'h0);
    chk($sformatf("%s:be", name), 32'(bus_be), 32'hF);
  endtask

  // gw: gnt wait cycles; rw: extra cycles from gnt to rvalid; tc_at: WAIT_TC cycle
  // index where tc rises (-1 = never); abort: assert reset in WR_EN's response phase.
  task automatic run_seq(input string name, input logic [31:0] t_base, input logic [31:0] t_thr,
                         input int gw, input int rw, input int tc_at, input logic [31:0] rval,
                         input bit stale_tc, input bit restart, input bit spur, input bit abort);
    logic [31:0] o_addr[5];
    logic [31:0] o_wdata[5];
    logic        o_we[5];
    logic [31:0] e_addr[5];
    logic [31:0] e_wdata[5];
    logic        e_we[5];
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    int n_txn = 0, gcnt = 0, rcnt = 0, wait_cnt = 0, done_cnt = 0, lat = -1, cyc = 0;
    int stable_bad = 0, overlap_bad = 0, busy_bad = 0, be_bad = 0, extra_req = 0;
    bit outst = 0, armed = 0, closed = 0, req_prev = 0, tc_hold = 0;
    logic to_seen = 1'b0, busy_at_done = 1'b1;
    bit exp_to;
    int exp_wait, exp_lat;

    e_we    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    e_addr  = '{t_base + 32'h4, t_base, t_base, t_base + 32'h8, t_base};
    e_wdata = '{t_thr, 32'h2, 32'h1, 32'h0, 32'h0};
    exp_to   = !(tc_at >= 0 && tc_at < 16);
    exp_wait = exp_to ? 16 : tc_at + 1;
    exp_lat  = 5 * (gw + rw + 2) + exp_wait + 1;

    @(negedge clk);
    start = 1'b1; base_addr = t_base; thr_val = t_thr;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; tc_int = 1'b0;

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; base_addr = $urandom; thr_val = $urandom;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom; tc_int = 1'b0;

      if (bus_be !== 4'hF) be_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (lat < 0) begin
          lat = cyc; busy_at_done = busy; to_seen = timeout;
        end
      end
      if (lat < 0 && busy !== 1'b1) busy_bad++;
      if (lat >= 0 && busy !== 1'b0) busy_bad++;
      if (lat >= 0 && bus_req === 1'b1) extra_req++;

      if (armed && !closed) begin
        if (bus_req === 1'b1) closed = 1;
        else begin
          if (tc_at >= 0 && wait_cnt >= tc_at) tc_hold = 1;
          if (restart && wait_cnt == 2) begin
            start = 1'b1; base_addr = 32'h1234_5670; thr_val = 32'h55;
          end
          wait_cnt++;
        end
      end
      if (tc_hold || (stale_tc && !armed)) tc_int = 1'b1;

      if (abort && outst && n_txn == 3 && bus_req !== 1'b1) begin
        rst_n = 1'b0;
        return;
      end

      if (bus_req === 1'b1) begin
        if (outst) overlap_bad++;
        else begin
          if (req_prev && (bus_addr !== h_addr || bus_wdata !== h_wdata || bus_we !== h_we))
            stable_bad++;
          h_addr = bus_addr; h_wdata = bus_wdata; h_we = bus_we;
          if (gcnt == gw) begin
            bus_gnt = 1'b1;
            if (n_txn < 5) begin
              o_we[n_txn] = bus_we; o_addr[n_txn] = bus_addr; o_wdata[n_txn] = bus_wdata;
            end
            n_txn++; outst = 1; gcnt = 0; rcnt = 0;
          end else begin
            gcnt++;
            if (spur) bus_rvalid = 1'($urandom_range(0, 1));
          end
        end
      end else if (outst) begin
        if (rcnt == rw) begin
          bus_rvalid = 1'b1; outst = 0;
          if (n_txn == 4) bus_rdata = rval;
          if (n_txn == 3) armed = 1;
        end else rcnt++;
      end
      req_prev = (bus_req === 1'b1) && !bus_gnt;
      if (lat >= 0 && cyc >= lat + 4) break;
    end

    chk($sformatf("%s:txns", name), 32'(n_txn), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s:we%0d", name, i), 32'(o_we[i]), 32'(e_we[i]));
      chk($sformatf("%s:addr%0d", name, i), o_addr[i], e_addr[i]);
      if (e_we[i]) chk($sformatf("%s:wdata%0d", name, i), o_wdata[i], e_wdata[i]);
    end
    chk($sformatf("%s:wait_cycles", name), 32'(wait_cnt), 32'(exp_wait));
    chk($sformatf("%s:done_count", name), 32'(done_cnt), 32'd1);
    chk($sformatf("%s:latency", name), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s:busy_at_done", name), 32'(busy_at_done), 32'h0);
    chk($sformatf("%s:timeout_at_done", name), 32'(to_seen), 32'(exp_to));
    chk($sformatf("%s:timeout_held", name), 32'(timeout), 32'(exp_to));
    chk($sformatf("%s:cnt", name), cnt, rval);
    chk($sformatf("%s:req_stable", name), 32'(stable_bad), 32'h0);
    chk($sformatf("%s:outstanding", name), 32'(overlap_bad), 32'h0);
    chk($sformatf("%s:busy_window", name), 32'(busy_bad), 32'h0);
    chk($sformatf("%s:be", name), 32'(be_bad), 32'h0);
    chk($sformatf("%s:extra_req", name), 32'(extra_req), 32'h0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; base_addr = '0; thr_val = '0; tc_int = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #2 rst_n = 1'b0;
    #10 check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_seq("t1", 32'h2000_0000, 32'd5, 0, 0, 6, 32'd5, 0, 0, 0, 0);
    run_seq("t2", $urandom, $urandom, 3, int'($urandom_range(0, 2)), int'($urandom_range(0, 10)),
            $urandom, 0, 0, 1, 0);
    run_seq("t3", $urandom, $urandom, 0, 1, -1, 32'hAB, 0, 0, 0, 0);
    run_seq("t4", $urandom, $urandom, 1, 0, 15, $urandom, 1, 0, 0, 0);
    run_seq("t5", 32'hFFFF_FFFC, $urandom, 0, 0, 5, $urandom, 0, 1, 0, 0);
    run_seq("min", $urandom, $urandom, 0, 0, 0, $urandom, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_seq($sformatf("rnd%0d", i), $urandom, $urandom, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 21)) - 1, $urandom | 32'h1,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    run_seq("t6", $urandom, $urandom, 1, 1, 3, $urandom, 0, 0, 0, 1);
    #1 check_reset("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq("t6_after", $urandom, $urandom, 0, 0, 2, $urandom, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
